// File: rtl/stream_arb_pkg.sv
// Shared types and width helpers for the round-robin stream arbiter.
package stream_arb_pkg;

    typedef enum logic {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } lock_state_e;

    function automatic int unsigned idx_width(int unsigned num_inp);
        return (num_inp > 1) ? $clog2(num_inp) : 1;
    endfunction

    function automatic int unsigned cnt_width(int unsigned max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/stream_rr_arb_sel.sv
// Rotating first-one finder: first set valid at or above ptr_i, wrapping past the last input.
module stream_rr_arb_sel
    import stream_arb_pkg::*;
#(
    parameter int unsigned NumInp   = 4,
    parameter int unsigned IdxWidth = idx_width(NumInp)
) (
    input  logic [NumInp-1:0]   valid_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_valid_o
);

    int unsigned         pos;
    logic [IdxWidth-1:0] cand;

    always_comb begin
        idx_o       = ptr_i;
        any_valid_o = 1'b0;
        pos         = 0;
        cand        = '0;
        for (int unsigned off = 0; off < NumInp; off++) begin
            pos = 32'(ptr_i) + off;
            if (pos >= NumInp) begin
                pos = pos - NumInp;
            end
            cand = IdxWidth'(pos);
            if (!any_valid_o && valid_i[cand]) begin
                any_valid_o = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arb.sv
// Round-robin ready/valid arbiter with per-requester burst allowance; a grant offered
// without a handshake is locked until it completes.
module stream_rr_arb
    import stream_arb_pkg::*;
#(
    parameter int unsigned NumInp       = 4,
    parameter type         data_t       = logic [31:0],
    parameter int unsigned MaxBurst     = 1,
    parameter bit          StabAssertEn = 1'b1,
    localparam int unsigned IdxWidth    = idx_width(NumInp)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  data_t [NumInp-1:0]       inp_data_i,
    input  logic  [NumInp-1:0]       inp_valid_i,
    output logic  [NumInp-1:0]       inp_ready_o,
    output data_t                    oup_data_o,
    output logic  [IdxWidth-1:0]     oup_idx_o,
    output logic                     oup_valid_o,
    input  logic                     oup_ready_i
);

    localparam int unsigned         CntWidth = cnt_width(MaxBurst);
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumInp - 1);

    lock_state_e         state_q, state_d;
    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic [IdxWidth-1:0] lidx_q, lidx_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic                lock_q;
    logic [IdxWidth-1:0] sel_idx, gnt_idx;
    logic                any_valid, hs;
    int unsigned         burst;
    logic                stab_viol;

    stream_rr_arb_sel #(
        .NumInp   (NumInp),
        .IdxWidth (IdxWidth)
    ) u_sel (
        .valid_i     (inp_valid_i),
        .ptr_i       (ptr_q),
        .idx_o       (sel_idx),
        .any_valid_o (any_valid)
    );

    assign lock_q    = (state_q == StLocked);
    assign stab_viol = lock_q && !inp_valid_i[lidx_q];

    // A locked grant is held regardless of the current valids, so the output stays stable.
    always_comb begin
        gnt_idx              = lock_q ? lidx_q : sel_idx;
        oup_valid_o          = lock_q | any_valid;
        oup_idx_o            = gnt_idx;
        oup_data_o           = inp_data_i[gnt_idx];
        inp_ready_o          = '0;
        inp_ready_o[gnt_idx] = oup_ready_i & oup_valid_o;
        hs                   = oup_valid_o & oup_ready_i;
    end

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        lidx_d  = lidx_q;
        burst   = 1;
        if (gnt_idx == ptr_q) begin
            burst = 32'(cnt_q) + 1;
        end
        if (hs) begin
            if (burst >= MaxBurst) begin
                ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + IdxWidth'(1);
                cnt_d = '0;
            end else begin
                ptr_d = gnt_idx;
                cnt_d = CntWidth'(burst);
            end
        end
        unique case (state_q)
            StUnlocked: begin
                if (oup_valid_o && !oup_ready_i) begin
                    state_d = StLocked;
                    lidx_d  = gnt_idx;
                end
            end
            StLocked: begin
                if (oup_ready_i) begin
                    state_d = StUnlocked;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StUnlocked;
            ptr_q   <= '0;
            cnt_q   <= '0;
            lidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lidx_q  <= lidx_d;
        end
    end

`ifndef SYNTHESIS
    a_max_burst: assert property (@(posedge clk_i) disable iff (rst_i) MaxBurst >= 1)
        else $error("stream_rr_arb: MaxBurst must be at least 1");
    a_num_inp: assert property (@(posedge clk_i) disable iff (rst_i) NumInp >= 1)
        else $error("stream_rr_arb: NumInp must be at least 1");
    a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i || !StabAssertEn)
        lock_q |-> (!stab_viol && oup_data_o == $past(oup_data_o)))
        else $error("stream_rr_arb: locked requester %0d changed valid/data", lidx_q);
`endif

endmodule
